// File: rtl/wb_arbiter.sv
// wb_arbiter: single-port register-file writeback arbiter between an unbuffered ALU path and a buffered LSU path.
// Optional build macro WB_COMMIT_CNT_EN adds a 32-bit commit_cnt output counting issued register writes.
module wb_arbiter #(
    parameter int LSU_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
`ifdef WB_COMMIT_CNT_EN
    output logic [31:0] commit_cnt,
`endif
    output logic        busy
);
    localparam int AW = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [4:0]    r_mem_rd   [LSU_FIFO_DEPTH];
    logic [31:0]   r_mem_data [LSU_FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_we;
    logic [4:0]    r_rd;
    logic [31:0]   r_wdata;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_win;
    logic [4:0]    w_rd;
    logic [31:0]   w_data;

    // Arbitration: a full FIFO outranks the ALU so loads cannot starve; otherwise ALU first.
    always_comb begin
        w_full  = (r_count == CW'(LSU_FIFO_DEPTH));
        w_empty = (r_count == '0);
        w_push  = lsu_valid && !w_full;
        w_pop   = w_full || (!alu_valid && !w_empty);
        w_win   = w_pop || alu_valid;
        w_rd    = w_pop ? r_mem_rd[r_rptr]   : alu_rd;
        w_data  = w_pop ? r_mem_data[r_rptr] : alu_data;
    end

    // FIFO storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= lsu_rd;
            r_mem_data[r_wptr] <= lsu_data;
        end
    end

    // FIFO pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Register the winner; x0 destinations are consumed but never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_win && (w_rd != 5'd0);
            if (w_win) begin
                r_rd    <= w_rd;
                r_wdata <= w_data;
            end
        end
    end

`ifdef WB_COMMIT_CNT_EN
    logic [31:0] r_commit;

    // Count cycles with a register-file write, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_commit <= '0;
        else        r_commit <= r_commit + 32'(r_we);
    end

    assign commit_cnt = r_commit;
`endif

    assign alu_ready = !w_full;
    assign lsu_ready = !w_full;
    assign rf_we     = r_we;
    assign rf_rd     = r_rd;
    assign rf_wdata  = r_wdata;
    assign busy      = !w_empty || r_we;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a queue-based writeback model.
module tb_wb_arbiter;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, rf_rd;
    logic [31:0] alu_data, lsu_data, rf_wdata;
    logic        rf_we, busy;
`ifdef WB_COMMIT_CNT_EN
    logic [31:0] commit_cnt;
`endif

    wb_arbiter #(.LSU_FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
`ifdef WB_COMMIT_CNT_EN
        .commit_cnt(commit_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        q_rd.delete();
        q_data.delete();
        m_we = 1'b0;
        m_rd = '0;
        m_wdata = '0;
        m_cnt = '0;
    endtask

    task automatic m_step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        logic full, win;
        logic [4:0] wr;
        logic [31:0] wd;
        full = (q_rd.size() == D);
        win = 1'b0;
        wr = '0;
        wd = '0;
        m_cnt += 32'(m_we);
        if (full || (!av && q_rd.size() > 0)) begin
            win = 1'b1;
            wr = q_rd.pop_front();
            wd = q_data.pop_front();
        end else if (av) begin
            win = 1'b1;
            wr = ard;
            wd = ad;
        end
        if (lv && !full) begin
            q_rd.push_back(lrd);
            q_data.push_back(ld);
        end
        m_we = win && (wr != 5'd0);
        if (win) begin
            m_rd = wr;
            m_wdata = wd;
        end
    endtask

    task automatic check_regs();
        check("rf_we", 32'(rf_we), 32'(m_we));
        check("rf_rd", 32'(rf_rd), 32'(m_rd));
        check("rf_wdata", rf_wdata, m_wdata);
`ifdef WB_COMMIT_CNT_EN
        check("commit_cnt", commit_cnt, m_cnt);
`endif
    endtask

    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        #1;
        check("alu_ready", 32'(alu_ready), 32'(q_rd.size() < D));
        check("lsu_ready", 32'(lsu_ready), 32'(q_rd.size() < D));
        check("busy", 32'(busy), 32'(q_rd.size() > 0 || m_we));
        m_step(av, ard, ad, lv, lrd, ld);
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        m_reset();
        #12;
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_rd", 32'(rf_rd), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1'b1, 5'd5, 32'h12345678, 1'b0, '0, '0);
        check("alu_only_we", 32'(rf_we), 32'd1);
        check("alu_only_data", rf_wdata, 32'h12345678);
        idle(1);
        check("alu_only_clear", 32'(rf_we), 32'd0);

        cyc(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
        check("same_cyc_first", 32'(rf_rd), 32'd1);
        idle(1);
        check("same_cyc_second", rf_wdata, 32'hB);
        idle(1);

        for (int i = 0; i < 4; i++) cyc(1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 5'(20 + i), 32'(200 + i));
        check("full_alu_ready", 32'(alu_ready), 32'd0);
        check("full_lsu_ready", 32'(lsu_ready), 32'd0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 5'd14, 32'(300 + i), 1'b1, 5'd25, 32'(400 + i));
        idle(8);
        check("drain_busy", 32'(busy), 32'd0);

        cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
        check("x0_we", 32'(rf_we), 32'd0);

        for (int i = 0; i < 3; i++) cyc(1'b1, 5'(3 + i), 32'(500 + i), 1'b1, 5'(7 + i), 32'(600 + i));
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("midrst_we", 32'(rf_we), 32'd0);
        check("midrst_wdata", rf_wdata, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_lsu_ready", 32'(lsu_ready), 32'd1);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < 10; i++) cyc(1'b1, (i == 3 || i == 7) ? 5'd0 : 5'(i + 1), 32'(700 + i), 1'b0, '0, '0);
        idle(2);
`ifdef WB_COMMIT_CNT_EN
        check("commit_eight", commit_cnt, 32'd8);
`endif

        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 99) < 55, 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom);
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
